sid_pot_ctrl: RTL

SID_POT_CTRL -- requirements
Module: sid_pot_ctrl

---
 rtl/sid_pkg.sv | 19 +
 rtl/sid_pot_chan.sv | 49 ++++
 rtl/sid_pot_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID paddle (POT) measurement logic.
`default_nettype none
package sid;

  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic [1:0] charged;
  } pot_i_t;

  typedef struct packed {
    logic [1:0] discharge;
  } pot_o_t;

  localparam int POT_DISCHARGE_CYCLES = 256;
  localparam int POT_CNT_W            = 9;

endpackage
`default_nettype wire

// File: rtl/sid_pot_chan.sv
// One POT channel: charge-detect filter, sticky charged flag and 8-bit ramp counter.
`default_nettype none
module sid_pot_chan
  import sid::*;
#(
  parameter int CHARGE_FILTER = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  charged,
  input  logic  charging,
  input  logic  clr_v,
  input  logic  inc_v,
  output reg8_t v
);

  localparam logic [2:0] FLT_MAX = 3'(CHARGE_FILTER);

  logic [2:0] filt;
  logic       chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      chg  <= 1'b0;
    end else if (!charging) begin
      filt <= '0;
      chg  <= 1'b0;
    end else if (charged) begin
      if (filt != FLT_MAX) filt <= filt + 3'd1;
      if (filt + 3'd1 == FLT_MAX) chg <= 1'b1;
    end else begin
      filt <= '0;
    end
  end

  // Increment sees the registered chg, so a flag rising this clk does not gate this tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (clr_v) begin
      v <= '0;
    end else if (inc_v && !chg && v != 8'hFF) begin
      v <= v + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sid_pot_ctrl.sv
// POT sequencer: phi2-falling-edge tick, 512-tick discharge/charge cycle and POTX/POTY latch.
`default_nettype none
module sid_pot_ctrl
  import sid::*;
#(
  parameter int CHARGE_FILTER = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   phi2,
  input  pot_i_t pot_i,
  output pot_o_t pot_o,
  output reg8_t  pot_x,
  output reg8_t  pot_y,
  output logic   pot_valid
);

  localparam logic [POT_CNT_W-1:0] CNT_CHG_START = POT_CNT_W'(POT_DISCHARGE_CYCLES);
  localparam logic [POT_CNT_W-1:0] CNT_DIS_LAST  = POT_CNT_W'(POT_DISCHARGE_CYCLES - 1);
  localparam logic [POT_CNT_W-1:0] CNT_LAST      = POT_CNT_W'(2 * POT_DISCHARGE_CYCLES - 1);

  logic                 phi2_d;
  logic                 tick;
  logic [POT_CNT_W-1:0] cnt;
  logic                 charging;
  logic                 clr_v;
  logic                 inc_v;
  logic                 latch;
  reg8_t                v_x;
  reg8_t                v_y;

  assign tick     = phi2_d & ~phi2;
  assign charging = cnt[POT_CNT_W-1];
  assign clr_v    = tick && (cnt == CNT_DIS_LAST);
  assign inc_v    = tick && (cnt >= CNT_CHG_START) && (cnt != CNT_LAST);
  assign latch    = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi2_d <= 1'b0;
      cnt    <= '0;
    end else begin
      phi2_d <= phi2;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Pad pull-downs decode straight from the registered counter.
  always_comb begin
    pot_o           = '0;
    pot_o.discharge = charging ? 2'b00 : 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pot_x     <= '0;
      pot_y     <= '0;
      pot_valid <= 1'b0;
    end else begin
      pot_valid <= latch;
      if (latch) begin
        pot_x <= v_x;
        pot_y <= v_y;
      end
    end
  end

  sid_pot_chan #(.CHARGE_FILTER(CHARGE_FILTER)) u_chan_x (
    .clk      (clk),
    .rst      (rst),
    .charged  (pot_i.charged[0]),
    .charging (charging),
    .clr_v    (clr_v),
    .inc_v    (inc_v),
    .v        (v_x)
  );

  sid_pot_chan #(.CHARGE_FILTER(CHARGE_FILTER)) u_chan_y (
    .clk      (clk),
    .rst      (rst),
    .charged  (pot_i.charged[1]),
    .charging (charging),
    .clr_v    (clr_v),
    .inc_v    (inc_v),
    .v        (v_y)
  );

endmodule
`default_nettype wire
